result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 176 +++++++++++++++++
 tb/tb_result_collector.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
// Module      : result_collector
// Description : Collects signed accelerator results and quantises each one on
//               entry: negative -> 0 (ReLU), otherwise arithmetic shift right by
//               SHIFT, saturated to the unsigned OUT_W range. Quantised values are
//               buffered in a DEPTH-entry FIFO with a valid/ready handshake on both
//               sides. The block also keeps a sticky saturation flag and counts
//               pops into frames of FRAME_LEN, pulsing frame_done at each frame end.
// Ports       : clk        - single clock, rising-edge state updates
//               reset      - asynchronous active-low reset
//               valid_in   - accelerator result valid
//               data_in    - signed accelerator result [IN_W]
//               ready_out  - collector can accept a result (count < DEPTH)
//               m_valid    - quantised result available (count > 0)
//               m_data     - quantised result at FIFO head [OUT_W]
//               m_ready    - downstream accepts m_data
//               count      - FIFO occupancy [clog2(DEPTH)+1]
//               sat_flag   - sticky: a pushed result saturated
//               frame_done - one-cycle pulse after the last pop of a frame
//               clear      - synchronous flush of FIFO, frame counter, sat_flag
// Revision    : 1.0 - initial release
// ============================================================================
module result_collector #(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 8,
   parameter int SHIFT     = 8,
   parameter int DEPTH     = 4,
   parameter int FRAME_LEN = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_in,
   input  logic [IN_W-1:0]          data_in,
   output logic                     ready_out,
   output logic                     m_valid,
   output logic [OUT_W-1:0]         m_data,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     sat_flag,
   output logic                     frame_done,
   input  logic                     clear
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
   localparam logic [c_FRM_W-1:0] c_FRAME_END = c_FRM_W'(FRAME_LEN - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [OUT_W-1:0]   mem_q [DEPTH];
   logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_CNT_W-1:0] count_q, count_d;
   logic [c_FRM_W-1:0] frame_q, frame_d;
   logic               sat_q, sat_d;
   logic               frame_done_q, frame_done_d;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   logic w_push;
   logic w_pop;

   assign ready_out = (count_q < c_DEPTH_CNT);
   assign m_valid   = (count_q != '0);
   assign w_push    = valid_in & ready_out;
   assign w_pop     = m_valid & m_ready;

   // ------------------------------------------------------------------------
   // Quantisation
   // Once the sign bit is known to be clear, any set bit above OUT_W in the
   // shifted value means the result exceeds 2^OUT_W-1.
   // ------------------------------------------------------------------------
   logic signed [IN_W-1:0] w_shifted;
   logic                   w_neg;
   logic                   w_over;
   logic                   w_sat;
   logic [OUT_W-1:0]       w_quant;

   assign w_shifted = $signed(data_in) >>> SHIFT;
   assign w_neg     = data_in[IN_W-1];
   assign w_over    = |w_shifted[IN_W-1:OUT_W];
   assign w_sat     = ~w_neg & w_over;

   always_comb begin
      w_quant = w_shifted[OUT_W-1:0];
      if (w_neg) begin
         w_quant = '0;
      end else if (w_over) begin
         w_quant = '1;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      frame_d      = frame_q;
      sat_d        = sat_q;
      frame_done_d = 1'b0;

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         frame_d  = '0;
         sat_d    = 1'b0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            sat_d    = sat_q | w_sat;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            if (frame_q == c_FRAME_END) begin
               frame_d      = '0;
               frame_done_d = 1'b1;
            end else begin
               frame_d = frame_q + c_FRM_W'(1);
            end
         end
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         frame_q      <= '0;
         sat_q        <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         frame_q      <= frame_d;
         sat_q        <= sat_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Storage needs no reset: m_data is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push && !clear) begin
         mem_q[wr_ptr_q] <= w_quant;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
   assign count      = count_q;
   assign sat_flag   = sat_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_collector
// Description : Self-checking bench for result_collector. A negedge monitor
//               keeps a queue of expected quantised values, pushed when a result
//               is accepted and popped when downstream takes one, plus a model of
//               occupancy, sat_flag and frame_done. Directed sequences cover the
//               quantisation corners, full/empty, clear, frame and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_collector;

   localparam int IN_W      = 32;
   localparam int OUT_W     = 8;
   localparam int SHIFT     = 8;
   localparam int DEPTH     = 4;
   localparam int FRAME_LEN = 16;
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   logic              clk      = 1'b0;
   logic              reset    = 1'b0;
   logic              valid_in = 1'b0;
   logic [IN_W-1:0]   data_in  = '0;
   logic              m_ready  = 1'b0;
   logic              clear    = 1'b0;
   logic              ready_out;
   logic              m_valid;
   logic [OUT_W-1:0]  m_data;
   logic [CNT_W-1:0]  count;
   logic              sat_flag;
   logic              frame_done;

   int checks = 0;
   int errors = 0;

   logic [OUT_W-1:0] sb_q[$];
   int               model_frame = 0;
   bit               model_sat   = 1'b0;
   bit               model_fd    = 1'b0;
   int               fd_pulses   = 0;

   result_collector #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .SHIFT     (SHIFT),
      .DEPTH     (DEPTH),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .ready_out  (ready_out),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .count      (count),
      .sat_flag   (sat_flag),
      .frame_done (frame_done),
      .clear      (clear)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference quantiser: ReLU, floor divide by 2^SHIFT, clamp to 255.
   function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] d, output bit sat);
      longint v;
      v   = longint'($signed(d));
      sat = 1'b0;
      if (v < 0) return '0;
      v = v / (longint'(1) << SHIFT);
      if (v > 255) begin
         sat = 1'b1;
         return 8'hFF;
      end
      return v[OUT_W-1:0];
   endfunction

   // Scoreboard monitor: inputs and outputs are stable at the falling edge.
   always @(negedge clk) begin
      bit do_push, do_pop, s;
      logic [OUT_W-1:0] qv;
      if (!reset) begin
         sb_q.delete();
         model_frame = 0;
         model_sat   = 1'b0;
         model_fd    = 1'b0;
      end else begin
         check_eq("count",      32'(count),      32'(sb_q.size()));
         check_eq("m_valid",    32'(m_valid),    32'(sb_q.size() != 0));
         check_eq("ready_out",  32'(ready_out),  32'(sb_q.size() < DEPTH));
         check_eq("sat_flag",   32'(sat_flag),   32'(model_sat));
         check_eq("frame_done", 32'(frame_done), 32'(model_fd));
         if (frame_done) fd_pulses++;
         if (sb_q.size() != 0) check_eq("m_data", 32'(m_data), 32'(sb_q[0]));
         do_pop  = m_ready && (sb_q.size() != 0);
         do_push = valid_in && (sb_q.size() < DEPTH);
         if (clear) begin
            sb_q.delete();
            model_frame = 0;
            model_sat   = 1'b0;
            model_fd    = 1'b0;
         end else begin
            model_fd = do_pop && (model_frame == FRAME_LEN - 1);
            if (do_pop) begin
               void'(sb_q.pop_front());
               model_frame = (model_frame == FRAME_LEN - 1) ? 0 : model_frame + 1;
            end
            if (do_push) begin
               qv = quant(data_in, s);
               sb_q.push_back(qv);
               model_sat = model_sat | s;
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      check_eq("rst_count",   32'(count),      32'd0);
      check_eq("rst_m_valid", 32'(m_valid),    32'd0);
      check_eq("rst_ready",   32'(ready_out),  32'd1);
      check_eq("rst_sat",     32'(sat_flag),   32'd0);
      check_eq("rst_fd",      32'(frame_done), 32'd0);
      check_eq("rst_m_data",  32'(m_data),     32'd0);

      // Release reset with a push already presented: accepted on the first edge
      @(posedge clk);
      #1;
      reset    = 1'b1;
      valid_in = 1'b1;
      data_in  = 32'h0000_1234;
      cycle();
      valid_in = 1'b0;
      check_eq("q_1234_data",  32'(m_data),   32'h12);
      check_eq("q_1234_count", 32'(count),    32'd1);
      check_eq("q_1234_sat",   32'(sat_flag), 32'd0);
      do_clear();

      // Negative input -> 0
      valid_in = 1'b1;
      data_in  = 32'hFFFF_FF00;
      cycle();
      valid_in = 1'b0;
      check_eq("q_neg_data", 32'(m_data),   32'h00);
      check_eq("q_neg_sat",  32'(sat_flag), 32'd0);

      // Saturating input while popping the previous entry
      valid_in = 1'b1;
      m_ready  = 1'b1;
      data_in  = 32'h0001_0000;
      cycle();
      valid_in = 1'b0;
      check_eq("q_sat_data", 32'(m_data),   32'hFF);
      check_eq("q_sat_flag", 32'(sat_flag), 32'd1);
      cycle();
      m_ready = 1'b0;
      check_eq("sat_sticky", 32'(sat_flag), 32'd1);
      check_eq("sat_empty",  32'(count),    32'd0);
      do_clear();
      check_eq("sat_cleared", 32'(sat_flag), 32'd0);

      // Overfill: 5 pushes into 4 entries
      for (int i = 1; i <= 5; i++) begin
         valid_in = 1'b1;
         data_in  = 32'(i) << 8;
         cycle();
      end
      valid_in = 1'b0;
      check_eq("full_count", 32'(count),     32'd4);
      check_eq("full_ready", 32'(ready_out), 32'd0);
      // Full with simultaneous push attempt and pop: only the pop happens
      valid_in = 1'b1;
      data_in  = 32'h0000_0900;
      m_ready  = 1'b1;
      cycle();
      valid_in = 1'b0;
      m_ready  = 1'b0;
      check_eq("full_pop_ready", 32'(ready_out), 32'd1);
      check_eq("full_pop_count", 32'(count),     32'd3);
      for (int i = 2; i <= 4; i++) begin
         check_eq("drain_order", 32'(m_data), 32'(i));
         m_ready = 1'b1;
         cycle();
         m_ready = 1'b0;
      end
      check_eq("drain_empty", 32'(count), 32'd0);
      // Pop request while empty must not underflow
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
      check_eq("empty_no_uflow", 32'(count), 32'd0);

      // Clear has priority over push and pop in the same cycle
      valid_in = 1'b1;
      data_in  = 32'h0000_0A00;
      cycle();
      cycle();
      clear   = 1'b1;
      m_ready = 1'b1;
      cycle();
      clear    = 1'b0;
      valid_in = 1'b0;
      m_ready  = 1'b0;
      check_eq("clear_prio_count", 32'(count), 32'd0);

      // Frame: stream 16 results, one push and one pop per cycle
      fd_pulses = 0;
      m_ready   = 1'b1;
      for (int i = 0; i < FRAME_LEN; i++) begin
         valid_in = 1'b1;
         data_in  = 32'(i + 16) << 8;
         cycle();
         check_eq("stream_count", 32'(count), 32'd1);
      end
      valid_in = 1'b0;
      cycle();
      check_eq("frame_done_pulse", 32'(frame_done), 32'd1);
      cycle();
      m_ready = 1'b0;
      check_eq("frame_done_once", 32'(fd_pulses), 32'd1);

      // Random traffic with occasional saturating and negative values
      for (int i = 0; i < 200; i++) begin
         valid_in = 1'($urandom_range(0, 1));
         m_ready  = ($urandom_range(0, 3) != 0);
         clear    = ($urandom_range(0, 31) == 0);
         case ($urandom_range(0, 3))
            0:       data_in = 32'($urandom) | 32'h8000_0000;
            1:       data_in = 32'($urandom_range(0, 32'h0002_0000));
            default: data_in = 32'($urandom_range(0, 32'h0000_FFFF));
         endcase
         cycle();
      end
      valid_in = 1'b0;
      m_ready  = 1'b0;
      clear    = 1'b0;

      // Asynchronous reset mid-operation with 3 entries stored
      do_clear();
      valid_in = 1'b1;
      data_in  = 32'h0000_0500;
      repeat (3) cycle();
      valid_in = 1'b0;
      check_eq("pre_areset_count", 32'(count), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      check_eq("areset_count",   32'(count),     32'd0);
      check_eq("areset_m_valid", 32'(m_valid),   32'd0);
      check_eq("areset_ready",   32'(ready_out), 32'd1);
      cycle();
      reset = 1'b1;
      repeat (3) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
